step_ctrl: RTL

STEP_CTRL -- requirements
Module: step_ctrl

---
 rtl/step_pkg.sv | 18 +
 rtl/sync2.sv | 33 +++
 rtl/step_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/step_pkg.sv
// ----------------------------------------------------------------------------
// step_pkg
// Shared definitions for the single-step controller:
//   - step_state_t : debounce FSM state encoding
//   - STEP_COUNT_W : width of the issued-step counter
// ----------------------------------------------------------------------------
package step_pkg;

    localparam int STEP_COUNT_W = 16;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } step_state_t;

endpackage

// File: rtl/sync2.sv
// ----------------------------------------------------------------------------
// sync2
// Generic two-flop synchronizer for raw asynchronous inputs. Adds two clk
// cycles of latency. Both stages clear on reset.
// Ports:
//   clk - system clock
//   rst - synchronous active-high reset
//   d   - asynchronous input, WIDTH bits
//   q   - synchronized output, WIDTH bits
// ----------------------------------------------------------------------------
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; only the second stage is used downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/step_ctrl.sv
// ----------------------------------------------------------------------------
// step_ctrl
// Debounced push-button single-step controller. A qualified button press
// produces one registered single-cycle step pulse; holding the button does
// not repeat. step_count tallies issued pulses and wraps at 16 bits.
//
// Optional feature macro: STEP_AUTORUN_EN
//   When defined, adds input 'run'. While run = 1 a wrapping divider emits one
//   step every AUTO_DIV cycles and button steps are suppressed. Dropping run
//   clears the divider.
//
// Parameters:
//   DEBOUNCE_CYCLES - consecutive stable samples needed to accept a change
//   AUTO_DIV        - auto-run step period in clk cycles (>= 2)
// Ports:
//   clk        - system clock
//   rst        - synchronous active-high reset
//   btn        - raw asynchronous button level, 1 = pressed
//   run        - auto-run request (STEP_AUTORUN_EN only)
//   step       - single-cycle step pulse
//   btn_level  - debounced button level
//   step_count - number of step pulses since reset
// ----------------------------------------------------------------------------
module step_ctrl
    import step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int AUTO_DIV        = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    btn,
`ifdef STEP_AUTORUN_EN
    input  logic                    run,
`endif
    output logic                    step,
    output logic                    btn_level,
    output logic [STEP_COUNT_W-1:0] step_count
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    // The sample that moves IDLE->PRESS_WAIT (or HELD->RELEASE_WAIT) is the
    // first of the qualifying run, and the final sample is the one taken in
    // the wait state when the transition fires, so the counter only has to
    // reach DEBOUNCE_CYCLES-2 before that last sample.
    localparam logic [CW-1:0] QUAL_LAST =
        CW'((DEBOUNCE_CYCLES >= 2) ? (DEBOUNCE_CYCLES - 2) : 0);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic        btn_sync;
    step_state_t state;
    logic [CW-1:0] deb_cnt;
    logic        press_done;
    logic        step_req;

    sync2 #(.WIDTH(1)) u_btn_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn),
        .q   (btn_sync)
    );

    // Debounce FSM. press_done marks the PRESS_WAIT->HELD edge; the step
    // pulse itself is registered one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            deb_cnt    <= '0;
            press_done <= 1'b0;
            btn_level  <= 1'b0;
        end else begin
            press_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_sync) begin
                        state   <= PRESS_WAIT;
                        deb_cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_sync) begin
                        state <= IDLE;
                    end else if (deb_cnt >= QUAL_LAST) begin
                        state      <= HELD;
                        btn_level  <= 1'b1;
                        press_done <= 1'b1;
                    end else if (deb_cnt != CNT_MAX) begin
                        deb_cnt <= deb_cnt + CW'(1);
                    end
                end
                HELD: begin
                    if (!btn_sync) begin
                        state   <= RELEASE_WAIT;
                        deb_cnt <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_sync) begin
                        state <= HELD;
                    end else if (deb_cnt >= QUAL_LAST) begin
                        state     <= IDLE;
                        btn_level <= 1'b0;
                    end else if (deb_cnt != CNT_MAX) begin
                        deb_cnt <= deb_cnt + CW'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    btn_level <= 1'b0;
                end
            endcase
        end
    end

`ifdef STEP_AUTORUN_EN
    localparam int AW = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_DIV - 1);

    logic [AW-1:0] auto_cnt;

    // Wrapping auto-run divider; held at zero whenever run is low so the
    // first auto step after run rises is a full period away.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            auto_cnt <= '0;
        end else if (auto_cnt == AUTO_LAST) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + AW'(1);
        end
    end

    assign step_req = run ? (auto_cnt == AUTO_LAST) : press_done;
`else
    assign step_req = press_done;
`endif

    // Step pulse and counter. A request landing right after a pulse (e.g. a
    // press completing the cycle after the last auto step) is dropped so the
    // pulse is never stretched over two cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            step       <= 1'b0;
            step_count <= '0;
        end else begin
            step <= step_req && !step;
            if (step_req && !step) begin
                step_count <= step_count + STEP_COUNT_W'(1);
            end
        end
    end

endmodule
